// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller for the 5-stage core.
// Merges stage stall requests into stall[5:0] ([0]PC..[5]WB,
// 1 = hold), arbitrates ID/EX redirects and holds one pending
// redirect while the front end is frozen. A watchdog raises a
// sticky stall_timeout after MAX_STALL frozen cycles.
// Ports: clk, rst (sync, active-low), *_stallreq, id/ex_b_flag,
// id/ex_b_target, stall, pc_redirect, redirect_pc, flush_if_id,
// flush_id_ex, stall_timeout, perf_stall_cycles, perf_redirects.
// Macro CTRL_PERF_EN builds the perf counters; else tied to 0.
module pipeline_ctrl #(
  parameter int MAX_STALL = 64,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_stallreq,
  input  logic        id_stallreq,
  input  logic        ex_stallreq,
  input  logic        mem_stallreq,
  input  logic        id_b_flag,
  input  logic [31:0] id_b_target,
  input  logic        ex_b_flag,
  input  logic [31:0] ex_b_target,
  output logic [5:0]  stall,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        stall_timeout,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_redirects
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(MAX_STALL);
  localparam logic [CNT_W-1:0] CNT_PRE =
    CNT_W'(MAX_STALL - 1);

  typedef struct packed {
    logic        valid;
    logic        src;
    logic [31:0] pc;
  } pend_t;

  pend_t            pend_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tmo_q;

  logic [5:0]  stall_req;
  logic        front;
  logic        sel_v;
  logic        sel_src;
  logic [31:0] sel_pc;

  always_comb begin
    stall_req = 6'b000000;
    priority case (1'b1)
      mem_stallreq: stall_req = 6'b011111;
      ex_stallreq:  stall_req = 6'b001111;
      id_stallreq:  stall_req = 6'b000111;
      if_stallreq:  stall_req = 6'b000011;
      default:      stall_req = 6'b000000;
    endcase
  end

  assign front = stall_req[0];

  // Live EX beats pending; pending beats live ID
  // because ID is younger than anything captured.
  always_comb begin
    sel_v   = 1'b0;
    sel_src = 1'b0;
    sel_pc  = 32'h0;
    if (!front) begin
      if (ex_b_flag) begin
        sel_v   = 1'b1;
        sel_src = 1'b1;
        sel_pc  = ex_b_target;
      end else if (pend_q.valid) begin
        sel_v   = 1'b1;
        sel_src = pend_q.src;
        sel_pc  = pend_q.pc;
      end else if (id_b_flag) begin
        sel_v   = 1'b1;
        sel_src = 1'b0;
        sel_pc  = id_b_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q <= '0;
    end else if (!front) begin
      pend_q.valid <= 1'b0;
    end else if (ex_b_flag) begin
      pend_q.valid <= 1'b1;
      pend_q.src   <= 1'b1;
      pend_q.pc    <= ex_b_target;
    end else if (id_b_flag && !pend_q.valid) begin
      pend_q.valid <= 1'b1;
      pend_q.src   <= 1'b0;
      pend_q.pc    <= id_b_target;
    end
  end

  // Timeout sets on the edge where the count
  // reaches MAX_STALL (or stays saturated there).
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else if (front) begin
      if (cnt_q != CNT_MAX)
        cnt_q <= cnt_q + 1'b1;
      if (cnt_q >= CNT_PRE)
        tmo_q <= 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  assign stall         = rst ? stall_req : 6'b0;
  assign pc_redirect   = rst & sel_v;
  assign redirect_pc   = pc_redirect ? sel_pc : 32'h0;
  assign flush_if_id   = pc_redirect;
  assign flush_id_ex   = pc_redirect & sel_src;
  assign stall_timeout = rst & tmo_q;

`ifdef CTRL_PERF_EN
  logic [31:0] pstall_q;
  logic [31:0] predir_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pstall_q <= 32'h0;
      predir_q <= 32'h0;
    end else begin
      if (front)
        pstall_q <= pstall_q + 32'h1;
      if (sel_v)
        predir_q <= predir_q + 32'h1;
    end
  end

  assign perf_stall_cycles = rst ? pstall_q : 32'h0;
  assign perf_redirects    = rst ? predir_q : 32'h0;
`else
  assign perf_stall_cycles = 32'h0;
  assign perf_redirects    = 32'h0;
`endif

endmodule
